// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 memory responder and its digest monitor.
package sha256_pkg;
    localparam int DIGEST_WORDS = 8;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_CAPTURE = 2'd1,
        MON_DONE    = 2'd2
    } mon_state_t;
endpackage

// File: rtl/sha256_digest_monitor.sv
// Watches in-range engine writes to the digest window and assembles the 8-word hash.
// state       | meaning
// MON_IDLE    | waiting for a write to DIGEST_BASE (word 0)
// MON_CAPTURE | words 0..k-1 stored, expecting DIGEST_BASE+k
// MON_DONE    | last digest published; behaves exactly like MON_IDLE
module sha256_digest_monitor
    import sha256_pkg::*;
#(
    parameter logic [15:0] DIGEST_BASE = 16'h0080
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           wr_valid,
    input  logic [15:0]                    wr_addr,
    input  logic [WORD_W-1:0]              wr_data,
    output logic [DIGEST_WORDS*WORD_W-1:0] digest,
    output logic                           digest_valid,
    output logic                           err_seq
);
    mon_state_t state, next_state;
    logic [2:0] k, next_k;
    logic [DIGEST_WORDS-1:0][WORD_W-1:0] words, words_next;
    logic [DIGEST_WORDS*WORD_W-1:0] digest_next;
    logic [15:0] offset;
    logic [2:0]  idx;
    logic        in_win, store, err_set, done;

    // Subtraction wraps addresses below the base to large values, so one compare covers both ends.
    assign offset = wr_addr - DIGEST_BASE;
    assign in_win = wr_valid && (offset < 16'(DIGEST_WORDS));
    assign idx    = offset[2:0];

    always_comb begin
        next_state = state;
        next_k     = k;
        store      = 1'b0;
        err_set    = 1'b0;
        done       = 1'b0;
        case (state)
            MON_IDLE, MON_DONE: begin
                if (in_win && idx == 3'd0) begin
                    store      = 1'b1;
                    next_k     = 3'd1;
                    next_state = MON_CAPTURE;
                end
            end
            MON_CAPTURE: begin
                if (in_win) begin
                    if (idx == 3'd0) begin
                        store   = 1'b1;
                        next_k  = 3'd1;
                        err_set = 1'b1;
                    end else if (idx == k) begin
                        store  = 1'b1;
                        next_k = 3'(k + 3'd1);
                        if (k == 3'(DIGEST_WORDS - 1)) begin
                            done       = 1'b1;
                            next_state = MON_DONE;
                        end
                    end else begin
                        err_set    = 1'b1;
                        next_state = MON_IDLE;
                    end
                end
            end
            default: next_state = MON_IDLE;
        endcase
        if (clear) begin
            next_state = MON_IDLE;
            next_k     = 3'd0;
            store      = 1'b0;
            done       = 1'b0;
        end
    end

    always_comb begin
        words_next = words;
        if (store) words_next[idx] = wr_data;
        digest_next = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            digest_next[(DIGEST_WORDS-1-i)*WORD_W +: WORD_W] = words_next[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= MON_IDLE;
            k            <= 3'd0;
            words        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err_seq      <= 1'b0;
        end else begin
            state        <= next_state;
            k            <= next_k;
            words        <= words_next;
            digest_valid <= done;
            if (done) digest <= digest_next;
            err_seq      <= (err_seq && !clear) || err_set;
        end
    end
endmodule

// File: rtl/sha256_mem_responder.sv
// Dual-port word memory serving a SHA-256 engine and a host, with access checks,
// an engine write counter and a digest capture monitor.
module sha256_mem_responder
    import sha256_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [15:0] DIGEST_BASE = 16'h0080
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_we,
    input  logic [15:0]                    mem_addr,
    input  logic [WORD_W-1:0]              mem_write_data,
    output logic [WORD_W-1:0]              mem_read_data,
    input  logic                           host_we,
    input  logic [15:0]                    host_addr,
    input  logic [WORD_W-1:0]              host_wdata,
    output logic [WORD_W-1:0]              host_rdata,
    input  logic                           clear,
    output logic                           digest_valid,
    output logic [DIGEST_WORDS*WORD_W-1:0] digest,
    output logic                           err_oor,
    output logic                           err_seq,
    output logic [15:0]                    wr_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] e_idx, h_idx;
    logic e_in, h_in, e_wr, h_wr;

    assign e_in  = {16'd0, mem_addr}  < 32'(DEPTH);
    assign h_in  = {16'd0, host_addr} < 32'(DEPTH);
    assign e_idx = mem_addr[AW-1:0];
    assign h_idx = host_addr[AW-1:0];
    assign e_wr  = mem_we && e_in;
    // On a same-address collision the engine owns the word.
    assign h_wr  = host_we && h_in && !(e_wr && mem_addr == host_addr);

    always_ff @(posedge clk) begin
        if (e_wr) mem[e_idx] <= mem_write_data;
        if (h_wr) mem[h_idx] <= host_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_data <= '0;
            host_rdata    <= '0;
            err_oor       <= 1'b0;
            wr_count      <= '0;
        end else begin
            mem_read_data <= e_in ? mem[e_idx] : '0;
            host_rdata    <= h_in ? mem[h_idx] : '0;
            err_oor       <= (err_oor && !clear) || !e_in || !h_in;
            if (clear)
                wr_count <= '0;
            else if (e_wr && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end

    sha256_digest_monitor #(
        .DIGEST_BASE (DIGEST_BASE)
    ) u_monitor (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .wr_valid     (e_wr),
        .wr_addr      (mem_addr),
        .wr_data      (mem_write_data),
        .digest       (digest),
        .digest_valid (digest_valid),
        .err_seq      (err_seq)
    );
endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed bench for sha256_mem_responder: table of single-cycle port vectors plus digest sequences.
module tb_sha256_mem_responder;
    localparam logic [15:0] BASE = 16'h0080;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [31:0]  host_wdata;
    logic [31:0]  host_rdata;
    logic         clear;
    logic         digest_valid;
    logic [255:0] digest;
    logic         err_oor;
    logic         err_seq;
    logic [15:0]  wr_count;

    int n_chk  = 0;
    int n_fail = 0;
    int dv_count = 0;
    int dv0;

    sha256_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .clear          (clear),
        .digest_valid   (digest_valid),
        .digest         (digest),
        .err_oor        (err_oor),
        .err_seq        (err_seq),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (digest_valid) dv_count++;

    typedef struct packed {
        logic        e_we;
        logic [15:0] e_addr;
        logic [31:0] e_wd;
        logic        h_we;
        logic [15:0] h_addr;
        logic [31:0] h_wd;
        logic        clr;
        logic [31:0] x_mrd;
        logic [31:0] x_hrd;
        logic        x_oor;
        logic [15:0] x_cnt;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic e_we, logic [15:0] e_addr, logic [31:0] e_wd,
                                logic h_we, logic [15:0] h_addr, logic [31:0] h_wd, logic clr,
                                logic [31:0] x_mrd, logic [31:0] x_hrd, logic x_oor, logic [15:0] x_cnt);
        vec_t v;
        v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.h_we = h_we; v.h_addr = h_addr; v.h_wd = h_wd; v.clr = clr;
        v.x_mrd = x_mrd; v.x_hrd = x_hrd; v.x_oor = x_oor; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e_we, input logic [15:0] e_addr, input logic [31:0] e_wd,
                         input logic h_we, input logic [15:0] h_addr, input logic [31:0] h_wd,
                         input logic clr);
        mem_we = e_we; mem_addr = e_addr; mem_write_data = e_wd;
        host_we = h_we; host_addr = h_addr; host_wdata = h_wd; clear = clr;
        cyc();
    endtask

    task automatic ew(input logic [15:0] a, input logic [31:0] d);
        drive(1'b1, a, d, 1'b0, 16'd0, 32'd0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b1);
    endtask

    logic [255:0] exp_a, exp_c, exp_e;

    initial begin
        reset = 1'b1;
        mem_we = 0; mem_addr = 0; mem_write_data = 0;
        host_we = 0; host_addr = 0; host_wdata = 0; clear = 0;

        vecs[0]  = mk(0, 16'd5,     32'd0,          0, 16'd7,     32'd0,          0, 32'd5,          32'd7,          0, 16'd0);
        vecs[1]  = mk(1, 16'd3,     32'hAAAA0003,   1, 16'd3,     32'hBBBB0003,   0, 32'd3,          32'd3,          0, 16'd1);
        vecs[2]  = mk(0, 16'd3,     32'd0,          0, 16'd3,     32'd0,          0, 32'hAAAA0003,   32'hAAAA0003,   0, 16'd1);
        vecs[3]  = mk(1, 16'd10,    32'h00001234,   0, 16'd10,    32'd0,          0, 32'd10,         32'd10,         0, 16'd2);
        vecs[4]  = mk(0, 16'd10,    32'd0,          1, 16'd11,    32'h00005555,   0, 32'h00001234,   32'd11,         0, 16'd2);
        vecs[5]  = mk(0, 16'd11,    32'd0,          0, 16'd19,    32'd0,          0, 32'h00005555,   32'd19,         0, 16'd2);
        vecs[6]  = mk(0, 16'h0100,  32'd0,          0, 16'd1,     32'd0,          0, 32'd0,          32'd1,          1, 16'd2);
        vecs[7]  = mk(0, 16'd5,     32'd0,          0, 16'd6,     32'd0,          1, 32'd5,          32'd6,          0, 16'd0);
        vecs[8]  = mk(1, 16'h0105,  32'hDEAD0105,   0, 16'd2,     32'd0,          0, 32'd0,          32'd2,          1, 16'd0);
        vecs[9]  = mk(0, 16'd5,     32'd0,          0, 16'd12,    32'd0,          0, 32'd5,          32'd12,         1, 16'd0);
        vecs[10] = mk(0, 16'd2,     32'd0,          0, 16'h0200,  32'd0,          1, 32'd2,          32'd0,          1, 16'd0);
        vecs[11] = mk(0, 16'd4,     32'd0,          0, 16'd4,     32'd0,          1, 32'd4,          32'd4,          0, 16'd0);

        exp_a = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        exp_c = 256'h000000B0_000000B1_000000B2_000000B3_000000B4_000000B5_000000B6_000000B7;
        exp_e = 256'hC0000000_C0000001_C0000002_C0000003_C0000004_C0000005_C0000006_C0000007;

        cyc(); cyc();
        chk("rst mem_read_data", mem_read_data, 0);
        chk("rst host_rdata", host_rdata, 0);
        chk("rst digest", digest, 0);
        chk("rst digest_valid", digest_valid, 0);
        chk("rst err_oor", err_oor, 0);
        chk("rst err_seq", err_seq, 0);
        chk("rst wr_count", wr_count, 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 20; i++) drive(1'b0, 16'd0, 32'd0, 1'b1, 16'(i), 32'(i), 1'b0);
        chk("host fill wr_count", wr_count, 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wd,
                  vecs[i].h_we, vecs[i].h_addr, vecs[i].h_wd, vecs[i].clr);
            chk($sformatf("vec%0d mem_read_data", i), mem_read_data, vecs[i].x_mrd);
            chk($sformatf("vec%0d host_rdata", i), host_rdata, vecs[i].x_hrd);
            chk($sformatf("vec%0d err_oor", i), err_oor, vecs[i].x_oor);
            chk($sformatf("vec%0d wr_count", i), wr_count, vecs[i].x_cnt);
        end

        // full capture with writes outside the window interleaved
        do_clear();
        dv0 = dv_count;
        for (int i = 0; i < 4; i++) ew(BASE + 16'(i), 32'h11111111 * 32'(i + 1));
        ew(16'h0020, 32'hFFFF0000);
        ew(BASE + 16'd8, 32'hFFFF0001);
        for (int i = 4; i < 7; i++) ew(BASE + 16'(i), 32'h11111111 * 32'(i + 1));
        chk("capA valid early", digest_valid, 0);
        ew(BASE + 16'd7, 32'h88888888);
        chk("capA valid pulse", digest_valid, 1);
        chk("capA digest", digest, exp_a);
        idle();
        chk("capA valid drop", digest_valid, 0);
        chk("capA pulse count", 256'(dv_count - dv0), 1);
        chk("capA err_seq", err_seq, 0);
        chk("capA wr_count", wr_count, 10);

        // skipped index -> error and back to IDLE
        do_clear();
        dv0 = dv_count;
        ew(BASE, 32'h1);
        ew(BASE + 16'd2, 32'h2);
        chk("skip err_seq", err_seq, 1);
        for (int i = 1; i < 8; i++) ew(BASE + 16'(i), 32'h3);
        idle();
        chk("skip no valid", 256'(dv_count - dv0), 0);
        chk("skip digest held", digest, exp_a);

        // clear mid-capture drops the partial sequence
        do_clear();
        chk("clear err_seq", err_seq, 0);
        dv0 = dv_count;
        ew(BASE, 32'h5);
        ew(BASE + 16'd1, 32'h6);
        do_clear();
        for (int i = 2; i < 8; i++) ew(BASE + 16'(i), 32'h7);
        idle();
        chk("clrcap no valid", 256'(dv_count - dv0), 0);
        chk("clrcap err_seq", err_seq, 0);

        // rewrite of word 0 restarts capture and flags the error
        do_clear();
        dv0 = dv_count;
        ew(BASE, 32'hA0);
        ew(BASE + 16'd1, 32'hA1);
        ew(BASE, 32'hB0);
        chk("restart err_seq", err_seq, 1);
        for (int i = 1; i < 8; i++) ew(BASE + 16'(i), 32'hB0 + 32'(i));
        idle();
        chk("restart pulse count", 256'(dv_count - dv0), 1);
        chk("restart digest", digest, exp_c);

        // reset mid-capture
        do_clear();
        for (int i = 0; i < 4; i++) ew(BASE + 16'(i), 32'hDEAD0000 + 32'(i));
        #2 reset = 1'b1;
        #1;
        chk("async rst digest", digest, 0);
        chk("async rst wr_count", wr_count, 0);
        cyc();
        reset = 1'b0;
        chk("midrst mem_read_data", mem_read_data, 0);
        chk("midrst err_seq", err_seq, 0);
        drive(1'b0, 16'd5, 32'd0, 1'b0, 16'd6, 32'd0, 1'b0);
        chk("mem kept eng", mem_read_data, 5);
        chk("mem kept host", host_rdata, 6);
        dv0 = dv_count;
        for (int i = 0; i < 8; i++) ew(BASE + 16'(i), 32'hC0000000 + 32'(i));
        idle();
        chk("post-rst pulse count", 256'(dv_count - dv0), 1);
        chk("post-rst digest", digest, exp_e);
        chk("post-rst err_seq", err_seq, 0);
        chk("post-rst wr_count", wr_count, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
